// File: rtl/sprite_pattern_loader_pkg.sv
// Shared constants and types for the sprite pattern write path.
// Addresses are {sprite_index, y[3:0], x[3:0]}, so one pattern holds 256 pixels.
package sprite_pattern_loader_pkg;

  localparam int SPRITE_DIM      = 16;
  localparam int SPRITE_PIX_BITS = 8;

  localparam logic [SPRITE_PIX_BITS-1:0] LAST_PIXEL = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  function automatic logic is_last_pixel(input logic [SPRITE_PIX_BITS-1:0] count);
    return (count == LAST_PIXEL);
  endfunction

endpackage

// File: rtl/sprite_write_fifo.sv
// Synchronous write buffer between the command side and the pattern RAM port.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sprite_write_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_pattern_loader.sv
// Write side of the sprite pattern RAM: raster-order address generation from a pixel
// stream, buffered so RAM writes only happen while vblank is high.
module sprite_pattern_loader
  import sprite_pattern_loader_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int PIXEL_BITS  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     cmd_valid,
  input  logic                                     cmd_start,
  input  logic [7:0]                               cmd_data,
  output logic                                     cmd_ready,
  input  logic                                     vblank,
  output logic                                     pat_we,
  output logic [$clog2(NUM_SPRITES)+SPRITE_PIX_BITS-1:0] pat_addr,
  output logic [PIXEL_BITS-1:0]                    pat_wdata,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error
);

  localparam int SIDX = $clog2(NUM_SPRITES);
  localparam int AW   = SIDX + SPRITE_PIX_BITS;
  localparam int EW   = AW + PIXEL_BITS + 1;
  localparam logic [7:0] NUM_SPRITES_B = 8'(NUM_SPRITES);

  state_t                     state, state_nx;
  logic [SIDX-1:0]            idx, idx_nx;
  logic [SPRITE_PIX_BITS-1:0] count, count_nx;
  logic                       accept;
  logic                       start_ok;
  logic                       push;
  logic                       pop;
  logic                       err_nx;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [EW-1:0]              push_entry;
  logic [EW-1:0]              pop_entry;

  assign cmd_ready  = ~fifo_full;
  assign accept     = cmd_valid & cmd_ready;
  assign start_ok   = (cmd_data < NUM_SPRITES_B);
  assign pop        = ~fifo_empty & vblank;
  // Entry layout: {address, pixel, last}
  assign push_entry = {idx, count, cmd_data[PIXEL_BITS-1:0], is_last_pixel(count)};
  assign busy       = (state == ST_LOAD) | ~fifo_empty | pat_we;

  sprite_write_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_entry),
    .rdata   (pop_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Command decode: pattern FSM, pixel counter and protocol error detection
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    count_nx = count;
    push     = 1'b0;
    err_nx   = 1'b0;
    if (accept && cmd_start) begin
      // A start during a load aborts it; the new index is still honoured if legal
      err_nx = (state == ST_LOAD) || !start_ok;
      if (start_ok) begin
        state_nx = ST_LOAD;
        idx_nx   = cmd_data[SIDX-1:0];
        count_nx = 8'd0;
      end else begin
        state_nx = ST_IDLE;
      end
    end else if (accept) begin
      case (state)
        ST_LOAD: begin
          push = 1'b1;
          if (is_last_pixel(count)) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_LOAD;
            count_nx = count + 8'd1;
          end
        end
        ST_IDLE: err_nx = 1'b1;
        default: state_nx = ST_IDLE;
      endcase
    end else begin
      state_nx = state;
    end
  end

  // Pattern state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      count <= 8'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      count <= count_nx;
    end
  end

  // RAM-side output registers; address and data hold between writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_we    <= 1'b0;
      pat_addr  <= '0;
      pat_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      pat_we <= pop;
      done   <= pop & pop_entry[0];
      error  <= err_nx;
      if (pop) begin
        pat_addr  <= pop_entry[EW-1 -: AW];
        pat_wdata <= pop_entry[PIXEL_BITS:1];
      end else begin
        pat_addr  <= pat_addr;
        pat_wdata <= pat_wdata;
      end
    end
  end

endmodule
